// File: rtl/fetch_unit_if.sv
// Fetch-to-ROM/decode bundle: ROM address and instruction return, decode control
// inputs, and the fetched instruction with its PC and status.
interface fetch_unit_if #(parameter int CNT_W = 32);
    logic [31:0]      Address;
    logic [31:0]      Instr;
    logic             Stall;
    logic             Branch;
    logic [15:0]      BranchOffset;
    logic             Jump;
    logic [25:0]      JumpTarget;
    logic             Halt;
    logic [31:0]      InstrOut;
    logic [31:0]      InstrPC;
    logic             InstrValid;
    logic             Halted;
    logic [CNT_W-1:0] FetchCount;

    modport master (
        input  Instr, Stall, Branch, BranchOffset, Jump, JumpTarget, Halt,
        output Address, InstrOut, InstrPC, InstrValid, Halted, FetchCount
    );
    modport slave (
        output Instr, Stall, Branch, BranchOffset, Jump, JumpTarget, Halt,
        input  Address, InstrOut, InstrPC, InstrValid, Halted, FetchCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the synchronous ROM, tags the
// returned word with its PC, and handles redirects, stalls and halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          CNT_W    = 32
) (
    input  logic CLK,
    input  logic RST,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FILL, RUN, HALTED} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      instr_pc;
    logic             instr_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    logic [31:0]      addr;
    logic [31:0]      ipc_plus1;
    logic [31:0]      br_target;
    logic [31:0]      jmp_target;

    assign ipc_plus1  = instr_pc + 32'd1;
    assign br_target  = ipc_plus1 + {{16{bus.BranchOffset[15]}}, bus.BranchOffset};
    assign jmp_target = {ipc_plus1[31:26], bus.JumpTarget};

    // A stalled live instruction re-reads its own word so InstrOut stays put.
    always_comb begin
        addr = pc;
        if (state != HALTED && bus.Stall && instr_valid)
            addr = instr_pc;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FILL;
            pc          <= RESET_PC;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    instr_pc    <= pc;
                    pc          <= pc + 32'd1;
                    instr_valid <= 1'b1;
                    if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    if (bus.Halt && instr_valid) begin
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                        state       <= HALTED;
                    end else if (bus.Stall) begin
                        instr_valid <= instr_valid;
                    end else if (bus.Jump && instr_valid) begin
                        pc          <= jmp_target;
                        instr_valid <= 1'b0;
                    end else if (bus.Branch && instr_valid) begin
                        pc          <= br_target;
                        instr_valid <= 1'b0;
                    end else begin
                        instr_pc    <= addr;
                        pc          <= addr + 32'd1;
                        instr_valid <= 1'b1;
                        if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.Address    = addr;
    assign bus.InstrOut   = bus.Instr;
    assign bus.InstrPC    = instr_pc;
    assign bus.InstrValid = instr_valid;
    assign bus.Halted     = halted;
    assign bus.FetchCount = fetch_count;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the synchronous instruction ROM. It owns the program counter and drives the word address into the ROM each cycle. It pairs the registered instruction word coming back with its PC and a valid flag, and handles branch/jump redirects, decode stalls and halt. There is no branch delay slot; the sequential word fetched behind a redirect is squashed.

Parameters:
RESET_PC, 0, word address loaded into PC on reset
CNT_W, 32, width of the fetch performance counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
Address  output  32  word address to the instruction ROM (ROM registers ROM[Address] into Instr on the next CLK edge)
Instr  input  32  registered instruction word returned by the ROM
Stall  input  1  downstream cannot accept a new instruction this cycle
Branch  input  1  taken branch for the current valid instruction
BranchOffset  input  16  signed word offset, from Instr[15:0]
Jump  input  1  jump for the current valid instruction
JumpTarget  input  26  word target, from Instr[25:0]
Halt  input  1  downstream requests permanent stop
InstrOut  output  32  instruction to decode (equals Instr)
InstrPC  output  32  word address of InstrOut
InstrValid  output  1  InstrOut is a live, non-squashed instruction
Halted  output  1  fetch has stopped
FetchCount  output  CNT_W  number of valid instructions delivered, saturating

Behaviour:
- The FSM has three states: FILL, RUN and HALTED. While RST is high the block is held in FILL with PC=RESET_PC, InstrPC=0, InstrValid=0, Halted=0 and FetchCount=0. All registers clear asynchronously.
- Address is combinational:
  - HALTED: Address=PC.
  - Otherwise, if Stall=1 and InstrValid=1: Address=InstrPC. The ROM re-reads the held word so InstrOut stays stable.
  - Otherwise: Address=PC.
- FILL: lasts one edge. At that edge InstrPC<=PC, PC<=PC+1 and InstrValid<=1, then the FSM goes to RUN. Inputs are ignored in FILL.
- RUN: each edge is evaluated in this priority order:
  1. Halt=1 with InstrValid=1: go to HALTED, InstrValid<=0, Halted<=1, PC frozen.
  2. Stall=1: PC, InstrPC and InstrValid are held. Redirects are ignored.
  3. Jump=1 with InstrValid=1: PC<={InstrPC_plus1[31:26], JumpTarget}, InstrValid<=0 (squash). Jump beats Branch when both are asserted.
  4. Branch=1 with InstrValid=1: PC<=InstrPC+1+sign_extend(BranchOffset), InstrValid<=0 (squash).
  5. Otherwise: InstrPC<=Address, PC<=Address+1, InstrValid<=1.
- After a squash, the next edge delivers the target instruction with InstrValid=1. The redirect penalty is therefore exactly 1 bubble cycle.
- Branch, Jump and Halt are ignored whenever InstrValid=0.
- All PC arithmetic is modulo 2^32. 0xFFFFFFFF+1 wraps to 0. Branch offsets wrap the same way.
- FetchCount increments by 1 on each edge where InstrValid becomes or remains 1 with a new InstrPC. Stall-held cycles do not count. The counter saturates at all-ones.
- HALTED: Address, PC and InstrPC are held, InstrValid=0 and Halted=1. Only RST leaves HALTED.
- RST asserted mid-operation (including mid-stall or in the squash cycle) immediately forces the reset values. A new FILL cycle follows deassertion.
- InstrOut is a pass-through of Instr. It is meaningful only when InstrValid=1.

Test Plan:
- Reset/sequential:
  - Stimulus: RESET_PC=0, release RST with no stalls.
  - Required response: Address goes 0,1,2,3 on successive cycles. InstrValid=0 during the first cycle, then 1 with InstrPC=0,1,2. InstrOut equals the ROM words for those addresses. FetchCount=3 after three valid deliveries.
- Branch/jump:
  - Stimulus: Branch=1 with BranchOffset=0xFFFD at InstrPC=5.
  - Required response: next cycle InstrValid=0 and Address=3; the following cycle InstrPC=3 with InstrValid=1.
  - Stimulus: Jump=1 and Branch=1 together with JumpTarget=0x10.
  - Required response: Address=0x10 (jump wins).
- Stall:
  - Stimulus: Stall=1 for 2 cycles while InstrPC=2.
  - Required response: Address=2, InstrOut and InstrPC=2 held, FetchCount unchanged. After release the next InstrPC=3.
  - Stimulus: Branch=1 asserted together with Stall=1.
  - Required response: the branch is ignored.
- Halt:
  - Stimulus: Halt=1 at InstrPC=6.
  - Required response: Halted=1 and InstrValid=0 from the next edge, Address frozen. Branch, Jump and Stall have no effect until RST.
- Wrap:
  - Stimulus: RESET_PC=0xFFFFFFFF.
  - Required response: InstrPC=0xFFFFFFFF, then 0x00000000 on the next delivery.
- Reset mid-op:
  - Stimulus: assert RST during the squash cycle after a branch.
  - Required response: all outputs return to reset values asynchronously. Fetch restarts at RESET_PC with a FILL cycle.
